// File: rtl/ysyx_ifq.sv
// ----------------------------------------------------------------------------
// ysyx_ifq
//   Speculation-aware instruction queue sitting between fetch and decode.
//   Each entry carries the instruction, its PC, the fetch-side speculation tag
//   and two predecode bits (branch-class, memory-class) computed at push time.
//   A wrong prediction truncates only the speculative tail of the queue; a
//   fence/trap/redirect empties the queue completely.
//
// Handshakes (both sides use the same valid/ready rule):
//   A transfer happens on a rising clk edge where the producer's valid and
//   the consumer's ready are both high.  Ready never depends on valid.
//   Fetch side : push = prev_valid & ready_o, ready_o = queue not full.
//   Decode side: pop  = valid_o & next_ready, valid_o = queue not empty.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   inst_i, pc_i    instruction and PC from fetch
//   spec_i          instruction fetched on a predicted path
//   prev_valid      fetch output valid
//   ready_o         queue can accept a push this cycle
//   good_spec_i     prediction correct: clear every spec tag
//   flush_spec_i    prediction wrong: drop the spec-tagged tail
//   flush_all_i     drop every entry
//   inst_o, pc_o    head instruction / PC (0 when empty)
//   spec_o          head spec tag
//   is_branch_o     head opcode is JAL, JALR, B-type or SYSTEM
//   is_mem_o        head opcode is LOAD or STORE
//   valid_o         head entry present
//   next_ready      decode accepts the head
//   count_o         occupied entries, 0..DEPTH
// ----------------------------------------------------------------------------
module ysyx_ifq #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              spec_i,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic              good_spec_i,
    input  logic              flush_spec_i,
    input  logic              flush_all_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] pc_o,
    output logic              spec_o,
    output logic              is_branch_o,
    output logic              is_mem_o,
    output logic              valid_o,
    input  logic              next_ready,
    output logic [PTR_W:0]    count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Storage
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DATA_W-1:0] pc_q   [DEPTH];
    logic [DEPTH-1:0]  br_q;
    logic [DEPTH-1:0]  mem_q;
    logic [DEPTH-1:0]  spec_q, spec_d;

    // Pointers and occupancy
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;

    logic              full_w;
    logic              empty_w;
    logic              push_req;
    logic              pop_req;
    logic              push_w;
    logic              pd_branch;
    logic              pd_mem;
    logic [PTR_W:0]    spec_k;

    assign full_w   = (cnt_q == FULL_CNT);
    assign empty_w  = (cnt_q == '0);
    assign ready_o  = !full_w;
    assign valid_o  = !empty_w;
    assign count_o  = cnt_q;

    assign push_req = prev_valid & ready_o;
    assign pop_req  = valid_o & next_ready;
    // Any flush discards the incoming instruction.
    assign push_w   = push_req & !flush_all_i & !flush_spec_i;

    // Predecode of the incoming instruction
    assign pd_branch = (inst_i[6:0] == OP_JAL)    || (inst_i[6:0] == OP_JALR) ||
                       (inst_i[6:0] == OP_BRANCH) || (inst_i[6:0] == OP_SYSTEM);
    assign pd_mem    = (inst_i[6:0] == OP_LOAD)   || (inst_i[6:0] == OP_STORE);

    // Offset from the head of the oldest speculative entry.  When no occupied
    // entry is speculative the offset equals the count, so a truncation to
    // spec_k keeps the whole queue.
    always_comb begin : find_spec
        logic           found;
        logic [PTR_W:0] off;
        logic [PTR_W-1:0] idx;
        spec_k = cnt_q;
        found  = 1'b0;
        off    = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = (PTR_W+1)'(i);
            idx = rd_q + off[PTR_W-1:0];
            if (!found && (off < cnt_q) && spec_q[idx]) begin
                found  = 1'b1;
                spec_k = off;
            end
        end
    end

    // Next-state for pointers, count and spec tags
    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        spec_d = spec_q;
        if (flush_all_i) begin
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
            spec_d = '0;
        end else if (flush_spec_i) begin
            // Survivors are all non-speculative, so every tag can be cleared.
            wr_d   = rd_q + spec_k[PTR_W-1:0];
            cnt_d  = spec_k;
            spec_d = '0;
            // A non-speculative head accepted this cycle is still consumed.
            if (pop_req && (spec_k != '0)) begin
                rd_d  = rd_q + 1'b1;
                cnt_d = spec_k - 1'b1;
            end
        end else begin
            if (good_spec_i) begin
                spec_d = '0;
            end
            if (push_w) begin
                wr_d         = wr_q + 1'b1;
                spec_d[wr_q] = spec_i & !good_spec_i;
            end
            if (pop_req) begin
                rd_d = rd_q + 1'b1;
            end
            if (push_w && !pop_req) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push_w && pop_req) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            spec_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            spec_q <= spec_d;
        end
    end

    // Payload; written only on an accepted, non-flushed push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            br_q  <= '0;
            mem_q <= '0;
        end else if (push_w) begin
            inst_q[wr_q] <= inst_i;
            pc_q[wr_q]   <= pc_i;
            br_q[wr_q]   <= pd_branch;
            mem_q[wr_q]  <= pd_mem;
        end
    end

    // Head outputs are forced to zero while the queue is empty so stale
    // entries never leak out (this also gives the reset values).
    assign inst_o      = valid_o ? inst_q[rd_q] : '0;
    assign pc_o        = valid_o ? pc_q[rd_q]   : '0;
    assign spec_o      = valid_o & spec_q[rd_q];
    assign is_branch_o = valid_o & br_q[rd_q];
    assign is_mem_o    = valid_o & mem_q[rd_q];

`ifndef SYNTHESIS
    // Speculative entries must form one contiguous run ending at the tail.
    logic contig_ok;
    always_comb begin : contig_chk
        logic           seen;
        logic [PTR_W:0] off;
        logic [PTR_W-1:0] idx;
        contig_ok = 1'b1;
        seen      = 1'b0;
        off       = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = (PTR_W+1)'(i);
            idx = rd_q + off[PTR_W-1:0];
            if (off < cnt_q) begin
                if (spec_q[idx]) begin
                    seen = 1'b1;
                end else if (seen) begin
                    contig_ok = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push_w && !ready_o)) else $error("push while not ready");
            assert (cnt_q <= FULL_CNT)     else $error("count exceeds depth");
            assert (contig_ok)             else $error("spec entries not contiguous");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_ifq.sv
module tb_ysyx_ifq;

  localparam int DEPTH = 4;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] JAL = 32'h0000006f;
  localparam logic [31:0] LW  = 32'h00002003;
  localparam logic [31:0] SW  = 32'h00002023;
  localparam logic [31:0] BEQ = 32'h00000063;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [31:0] inst_i, pc_i;
  logic        spec_i, prev_valid, good_spec_i, flush_spec_i, flush_all_i, next_ready;
  logic        ready_o, spec_o, is_branch_o, is_mem_o, valid_o;
  logic [31:0] inst_o, pc_o;
  logic [2:0]  count_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ysyx_ifq #(.DATA_W(32), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .pc_i(pc_i), .spec_i(spec_i), .prev_valid(prev_valid),
    .ready_o(ready_o), .good_spec_i(good_spec_i), .flush_spec_i(flush_spec_i),
    .flush_all_i(flush_all_i), .inst_o(inst_o), .pc_o(pc_o), .spec_o(spec_o),
    .is_branch_o(is_branch_o), .is_mem_o(is_mem_o), .valid_o(valid_o),
    .next_ready(next_ready), .count_o(count_o)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        spec;
  } ent_t;

  ent_t mq[$];

  function automatic logic m_branch(input logic [31:0] ins);
    return ins[6:0] inside {7'h6f, 7'h67, 7'h63, 7'h73};
  endfunction

  function automatic logic m_mem(input logic [31:0] ins);
    return ins[6:0] inside {7'h03, 7'h23};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      bit   do_push, do_pop;
      int   k;
      ent_t e;
      do_push = prev_valid && (mq.size() < DEPTH);
      do_pop  = next_ready && (mq.size() > 0);
      if (flush_all_i) begin
        mq.delete();
      end else if (flush_spec_i) begin
        k = mq.size();
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].spec) k = i;
        while (mq.size() > k) void'(mq.pop_back());
        if (do_pop && k > 0) void'(mq.pop_front());
      end else begin
        if (good_spec_i) foreach (mq[i]) mq[i].spec = 1'b0;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.inst = inst_i;
          e.pc   = pc_i;
          e.spec = spec_i && !good_spec_i;
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("valid", {31'b0, valid_o}, {31'b0, mq.size() > 0});
    chk("ready", {31'b0, ready_o}, {31'b0, mq.size() < DEPTH});
    chk("count", {29'b0, count_o}, 32'(mq.size()));
    if (mq.size() > 0) begin
      chk("inst", inst_o, mq[0].inst);
      chk("pc", pc_o, mq[0].pc);
      chk("spec", {31'b0, spec_o}, {31'b0, mq[0].spec});
      chk("is_branch", {31'b0, is_branch_o}, {31'b0, m_branch(mq[0].inst)});
      chk("is_mem", {31'b0, is_mem_o}, {31'b0, m_mem(mq[0].inst)});
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic pv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic sp, input logic nr, input logic gs,
                      input logic fs, input logic fa);
    prev_valid   = pv;
    inst_i       = ins;
    pc_i         = pc;
    spec_i       = sp;
    next_ready   = nr;
    good_spec_i  = gs;
    flush_spec_i = fs;
    flush_all_i  = fa;
    @(negedge clk);
  endtask

  task automatic pop1();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc, input logic sp);
    step(1'b1, ins, pc, sp, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    prev_valid = 0; inst_i = 0; pc_i = 0; spec_i = 0; next_ready = 0;
    good_spec_i = 0; flush_spec_i = 0; flush_all_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_count", {29'b0, count_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: fill, then drain in order
    for (int i = 0; i < 4; i++) push1(NOP, 32'h30000000 + 32'(4 * i), 1'b0);
    chk("fill_ready", {31'b0, ready_o}, 32'd0);
    chk("fill_count", {29'b0, count_o}, 32'd4);
    chk("fill_pc", pc_o, 32'h30000000);
    push1(NOP, 32'h30000010, 1'b0);  // refused while full
    chk("full_count", {29'b0, count_o}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      pop1();
      if (i < 3) chk("drain_pc", pc_o, 32'h30000000 + 32'(4 * (i + 1)));
    end
    chk("drain_valid", {31'b0, valid_o}, 32'd0);

    // 2: push+pop at count 1 across the pointer wrap
    push1(NOP, 32'h40000000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, NOP, 32'h40000000 + 32'(4 * (i + 1)), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("wrap_count", {29'b0, count_o}, 32'd1);
      chk("wrap_pc", pc_o, 32'h40000000 + 32'(4 * (i + 1)));
    end
    pop1();
    chk("wrap_empty", {29'b0, count_o}, 32'd0);

    // 3: bad speculation truncates the spec tail; same-cycle push dropped
    push1(NOP, 32'h50000000, 1'b0);
    push1(JAL, 32'h50000004, 1'b0);
    push1(NOP, 32'h50000008, 1'b1);
    push1(NOP, 32'h5000000c, 1'b1);
    step(1'b1, NOP, 32'h50000010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bad_count", {29'b0, count_o}, 32'd2);
    chk("bad_pc", pc_o, 32'h50000000);
    push1(NOP, 32'h50000020, 1'b0);
    pop1();
    chk("bad_pc_b", pc_o, 32'h50000004);
    chk("bad_br_b", {31'b0, is_branch_o}, 32'd1);
    pop1();
    chk("bad_pc_f", pc_o, 32'h50000020);
    pop1();
    chk("bad_empty", {31'b0, valid_o}, 32'd0);

    // 4: bad speculation with the non-spec head popped in the same cycle
    push1(NOP, 32'h50000000, 1'b0);
    push1(JAL, 32'h50000004, 1'b0);
    push1(NOP, 32'h50000008, 1'b1);
    push1(NOP, 32'h5000000c, 1'b1);
    step(1'b0, NOP, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("fpop_count", {29'b0, count_o}, 32'd1);
    chk("fpop_pc", pc_o, 32'h50000004);
    chk("fpop_br", {31'b0, is_branch_o}, 32'd1);
    pop1();
    chk("fpop_empty", {31'b0, valid_o}, 32'd0);

    // 5: good speculation clears tags, including a same-cycle spec push
    push1(LW, 32'h60000000, 1'b1);
    push1(SW, 32'h60000004, 1'b1);
    chk("gs_pre_spec", {31'b0, spec_o}, 32'd1);
    step(1'b1, BEQ, 32'h60000008, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gs_count", {29'b0, count_o}, 32'd3);
    chk("gs_spec0", {31'b0, spec_o}, 32'd0);
    chk("gs_mem0", {31'b0, is_mem_o}, 32'd1);
    pop1();
    chk("gs_spec1", {31'b0, spec_o}, 32'd0);
    chk("gs_mem1", {31'b0, is_mem_o}, 32'd1);
    pop1();
    chk("gs_spec2", {31'b0, spec_o}, 32'd0);
    chk("gs_br2", {31'b0, is_branch_o}, 32'd1);
    chk("gs_mem2", {31'b0, is_mem_o}, 32'd0);
    pop1();

    // 6: flush_all with push and pop at count 3, then async reset mid-burst
    for (int i = 0; i < 3; i++) push1(NOP, 32'h70000000 + 32'(4 * i), 1'b0);
    step(1'b1, NOP, 32'h7000000c, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("fa_count", {29'b0, count_o}, 32'd0);
    chk("fa_valid", {31'b0, valid_o}, 32'd0);
    push1(JAL, 32'h70000100, 1'b1);
    push1(LW, 32'h70000104, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    chk("arst_ready", {31'b0, ready_o}, 32'd1);
    chk("arst_count", {29'b0, count_o}, 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_inst", inst_o, 32'd0);
    chk("arst_spec", {31'b0, spec_o}, 32'd0);
    chk("arst_br", {31'b0, is_branch_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push1(NOP, 32'h80000000, 1'b0);
    chk("post_pc", pc_o, 32'h80000000);
    pop1();
    chk("post_empty", {31'b0, valid_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
